ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx_if.sv | 29 ++
 rtl/ps2_host_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if -- host-side request/status bundle for the PS/2 host transmitter.
// The master modport belongs to whoever issues command bytes; the slave
// modport is the transmitter itself.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output busy,
    output done,
    output error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
// Inhibits the bus, issues a request-to-send, shifts a byte plus odd parity
// on device clock falling edges, checks the device ack and reports done or
// error. Optional build macro PS2_TX_RETRY_EN: a NACK or timeout causes one
// automatic re-send of the same byte before error is reported.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic           clk_in,
  input  logic           reset,
  ps2_host_tx_if.slave   host,
  input  logic           ps2_clock_in,
  input  logic           ps2_data_in,
  output logic           ps2_clock_drive_low,
  output logic           ps2_data_drive_low
);

  // One counter serves both the inhibit delay and the transfer timeout,
  // so it is sized for the larger of the two.
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    RECOVER
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       bit_idx_reg;
  logic [7:0]       byte_reg;
  logic             parity_reg;
  logic             ack_ok_reg;
  logic             clock_drive_reg;
  logic             data_drive_reg;
  logic             done_reg;
  logic             error_reg;

  // Synchronised line samples: bit 0 = clock, bit 1 = data.
  logic [1:0] line_raw;
  logic [1:0] line_sync;
  logic       clock_prev_reg;
  logic       clock_fall;
  logic       retry_avail;

  assign line_raw = {ps2_data_in, ps2_clock_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      // Two-flop synchroniser; idle bus level is high, so reset to 1 to
      // avoid a phantom falling edge after reset.
      always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= line_raw[gi];
          sync_reg <= meta_reg;
        end
      end
      assign line_sync[gi] = sync_reg;
    end
  endgenerate

  // Previous synchronised clock, for falling-edge detection.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      clock_prev_reg <= 1'b1;
    end else begin
      clock_prev_reg <= line_sync[0];
    end
  end

  assign clock_fall = clock_prev_reg & ~line_sync[0];

`ifdef PS2_TX_RETRY_EN
  logic retried_reg;
  assign retry_avail = ~retried_reg;
`else
  assign retry_avail = 1'b0;
`endif

  // Transfer sequencer with registered line drives and status pulses.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      bit_idx_reg     <= '0;
      byte_reg        <= '0;
      parity_reg      <= 1'b0;
      ack_ok_reg      <= 1'b0;
      clock_drive_reg <= 1'b0;
      data_drive_reg  <= 1'b0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retried_reg     <= 1'b0;
`endif
    end else begin
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          clock_drive_reg <= 1'b0;
          data_drive_reg  <= 1'b0;
          if (host.tx_valid) begin
            byte_reg        <= host.tx_data;
            parity_reg      <= ~^host.tx_data;
            state_reg       <= INHIBIT;
            clock_drive_reg <= 1'b1;
            cnt_reg         <= '0;
            bit_idx_reg     <= '0;
`ifdef PS2_TX_RETRY_EN
            retried_reg     <= 1'b0;
`endif
          end
        end

        INHIBIT: begin
          // Clock held low for INHIBIT_CYCLES with data free, then one
          // cycle with both low before the clock is let go.
          if (data_drive_reg) begin
            state_reg       <= REQ;
            clock_drive_reg <= 1'b0;
            cnt_reg         <= '0;
          end else if (cnt_reg == INH_LAST) begin
            data_drive_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        REQ, SHIFT, ACK: begin
          if (cnt_reg == TO_LAST) begin
            // Device never finished clocking the frame.
            if (retry_avail) begin
              state_reg       <= INHIBIT;
              clock_drive_reg <= 1'b1;
              data_drive_reg  <= 1'b0;
              cnt_reg         <= '0;
              bit_idx_reg     <= '0;
`ifdef PS2_TX_RETRY_EN
              retried_reg     <= 1'b1;
`endif
            end else begin
              state_reg       <= IDLE;
              clock_drive_reg <= 1'b0;
              data_drive_reg  <= 1'b0;
              error_reg       <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
            if (clock_fall) begin
              if (state_reg == REQ) begin
                data_drive_reg <= ~byte_reg[0];
                bit_idx_reg    <= 4'd1;
                state_reg      <= SHIFT;
              end else if (state_reg == SHIFT) begin
                if (bit_idx_reg < 4'd8) begin
                  data_drive_reg <= ~byte_reg[bit_idx_reg[2:0]];
                  bit_idx_reg    <= bit_idx_reg + 4'd1;
                end else if (bit_idx_reg == 4'd8) begin
                  data_drive_reg <= ~parity_reg;
                  bit_idx_reg    <= 4'd9;
                end else begin
                  // Stop bit: line released, device will pull it for ack.
                  data_drive_reg <= 1'b0;
                  state_reg      <= ACK;
                end
              end else begin
                ack_ok_reg <= ~line_sync[1];
                state_reg  <= RECOVER;
              end
            end
          end
        end

        RECOVER: begin
          clock_drive_reg <= 1'b0;
          data_drive_reg  <= 1'b0;
          if (line_sync[0] && line_sync[1]) begin
            if (ack_ok_reg) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end else if (retry_avail) begin
              state_reg       <= INHIBIT;
              clock_drive_reg <= 1'b1;
              cnt_reg         <= '0;
              bit_idx_reg     <= '0;
`ifdef PS2_TX_RETRY_EN
              retried_reg     <= 1'b1;
`endif
            end else begin
              state_reg <= IDLE;
              error_reg <= 1'b1;
            end
          end
        end

        default: begin
          state_reg       <= IDLE;
          clock_drive_reg <= 1'b0;
          data_drive_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign host.tx_ready       = (state_reg == IDLE);
  assign host.busy           = (state_reg != IDLE);
  assign host.done           = done_reg;
  assign host.error          = error_reg;
  assign ps2_clock_drive_low = clock_drive_reg;
  assign ps2_data_drive_low  = data_drive_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- directed bench for ps2_host_tx with a wired-AND bus and
// a simple keyboard model that clocks frames and optionally acks.
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int TO   = 400;
  localparam int HALF = 8;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  logic ps2_clock_in;
  logic ps2_data_in;
  logic ps2_clock_drive_low;
  logic ps2_data_drive_low;
  logic dev_clk_drv  = 1'b0;
  logic dev_data_drv = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  ps2_host_tx_if ifc ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in              (clk_in),
    .reset               (reset),
    .host                (ifc),
    .ps2_clock_in        (ps2_clock_in),
    .ps2_data_in         (ps2_data_in),
    .ps2_clock_drive_low (ps2_clock_drive_low),
    .ps2_data_drive_low  (ps2_data_drive_low)
  );

  always #5 clk_in = ~clk_in;

  // Open-drain bus with pull-ups.
  assign ps2_clock_in = ~(ps2_clock_drive_low | dev_clk_drv);
  assign ps2_data_in  = ~(ps2_data_drive_low | dev_data_drv);

  // Bus monitor: cumulative event counters.
  int   done_cnt = 0, err_cnt = 0, both_pulse_cnt = 0;
  int   inh_cycles = 0, both_drv_cycles = 0, inh_phases = 0;
  logic clk_drv_prev = 1'b0;

  always @(negedge clk_in) begin
    if (ifc.done) done_cnt <= done_cnt + 1;
    if (ifc.error) err_cnt <= err_cnt + 1;
    if (ifc.done && ifc.error) both_pulse_cnt <= both_pulse_cnt + 1;
    if (ps2_clock_drive_low && !ps2_data_drive_low) inh_cycles <= inh_cycles + 1;
    if (ps2_clock_drive_low && ps2_data_drive_low) both_drv_cycles <= both_drv_cycles + 1;
    if (ps2_clock_drive_low && !clk_drv_prev) inh_phases <= inh_phases + 1;
    clk_drv_prev <= ps2_clock_drive_low;
  end

  int d0, e0, i0, b0, p0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    #1;
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cycles; b0 = both_drv_cycles; p0 = inh_phases;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_in);
    ifc.tx_data  = b;
    ifc.tx_valid = 1'b1;
    @(negedge clk_in);
    ifc.tx_valid = 1'b0;
  endtask

  // Keyboard model: waits for request-to-send, clocks n_edges falling edges,
  // samples data on each rising edge, pulls data low for ack if asked.
  task automatic device_frame(input int n_edges, input bit ack,
                              output logic [9:0] frame, output bit seen);
    int t;
    t = 0;
    frame = '0;
    seen  = 1'b0;
    while (!(ps2_data_drive_low && !ps2_clock_drive_low) && t < 2000) begin
      @(negedge clk_in);
      t++;
    end
    if (t >= 2000) return;
    seen = 1'b1;
    repeat (10) @(negedge clk_in);
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11) repeat (4) @(negedge clk_in);
      dev_clk_drv = 1'b1;
      repeat (HALF) @(negedge clk_in);
      dev_clk_drv = 1'b0;
      repeat (HALF) @(negedge clk_in);
      if (k <= 10) frame[k-1] = ps2_data_in;
      if (k == 10 && ack) dev_data_drv = 1'b1;
    end
    dev_data_drv = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (ifc.busy && t < 3000) begin
      @(negedge clk_in);
      t++;
    end
    check({tag, "_idle_in_time"}, 32'(ifc.busy), 32'd0);
    repeat (3) @(negedge clk_in);
    #1;
  endtask

  task automatic frame_checks(input string tag, input logic [9:0] frame, input bit seen,
                              input logic [7:0] exp_byte, input logic exp_par);
    check({tag, "_req_seen"}, 32'(seen), 32'd1);
    check({tag, "_data"}, 32'(frame[7:0]), 32'(exp_byte));
    check({tag, "_parity"}, 32'(frame[8]), 32'(exp_par));
    check({tag, "_stop"}, 32'(frame[9]), 32'd1);
    $display("[TB] %s: frame data=0x%02h parity=%0b stop=%0b", tag, frame[7:0], frame[8], frame[9]);
  endtask

  // Send, let the device ack, check frame and status.
  task automatic run_ack(input string tag, input logic [7:0] b, input logic exp_par);
    logic [9:0] frame;
    bit         seen;
    snap();
    check({tag, "_ready_before"}, 32'(ifc.tx_ready), 32'd1);
    send_byte(b);
    check({tag, "_busy_after_accept"}, 32'(ifc.busy), 32'd1);
    device_frame(11, 1'b1, frame, seen);
    wait_idle(tag);
    frame_checks(tag, frame, seen, b, exp_par);
    check({tag, "_inhibit_cycles"}, 32'(inh_cycles - i0), 32'(INH));
    check({tag, "_both_driven"}, 32'(both_drv_cycles - b0), 32'd1);
    check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_error"}, 32'(err_cnt - e0), 32'd0);
    check({tag, "_busy_end"}, 32'(ifc.busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;
    logic [9:0] frame2;
    bit         seen;
    bit         seen2;
    int         t;

    ifc.tx_data  = 8'h00;
    ifc.tx_valid = 1'b0;

    // Reset state, with tx_valid asserted: reset must win.
    ifc.tx_valid = 1'b1;
    ifc.tx_data  = 8'hAA;
    repeat (3) @(negedge clk_in);
    check("rst_ready", 32'(ifc.tx_ready), 32'd1);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_error", 32'(ifc.error), 32'd0);
    check("rst_clk_drv", 32'(ps2_clock_drive_low), 32'd0);
    check("rst_dat_drv", 32'(ps2_data_drive_low), 32'd0);
    ifc.tx_valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk_in);
    check("post_rst_busy", 32'(ifc.busy), 32'd0);

    // 0xED: bits 1,0,1,1,0,1,1,1, six ones -> parity 1.
    run_ack("ed", 8'hED, 1'b1);
    // 0x01: one one -> parity 0. 0x00: zero ones -> parity 1.
    run_ack("x01", 8'h01, 1'b0);
    run_ack("x00", 8'h00, 1'b1);

    // Reset after the fifth edge. 0x86 has bit4=0, so data is pulled low then.
    snap();
    send_byte(8'h86);
    device_frame(5, 1'b0, frame, seen);
    check("mid_req_seen", 32'(seen), 32'd1);
    check("mid_pre_dat_drv", 32'(ps2_data_drive_low), 32'd1);
    @(negedge clk_in);
    reset = 1'b1;
    #1;
    check("mid_rst_clk_drv", 32'(ps2_clock_drive_low), 32'd0);
    check("mid_rst_dat_drv", 32'(ps2_data_drive_low), 32'd0);
    check("mid_rst_ready", 32'(ifc.tx_ready), 32'd1);
    check("mid_rst_busy", 32'(ifc.busy), 32'd0);
    @(negedge clk_in);
    reset = 1'b0;
    #1;
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cycles; b0 = both_drv_cycles;
    ifc.tx_data  = 8'h55;
    ifc.tx_valid = 1'b1;
    @(negedge clk_in);
    ifc.tx_valid = 1'b0;
    check("mid_new_accept", 32'(ifc.busy), 32'd1);
    device_frame(11, 1'b1, frame, seen);
    wait_idle("mid55");
    // 0x55: four ones -> parity 1.
    frame_checks("mid55", frame, seen, 8'h55, 1'b1);
    check("mid55_done", 32'(done_cnt - d0), 32'd1);
    check("mid55_error", 32'(err_cnt - e0), 32'd0);
    check("mid55_inhibit_cycles", 32'(inh_cycles - i0), 32'(INH));

    // tx_valid with another byte during SHIFT is ignored; 0xA5 has four ones -> parity 1.
    snap();
    send_byte(8'hA5);
    fork
      device_frame(11, 1'b1, frame, seen);
      begin
        repeat (70) @(negedge clk_in);
        check("shift_ready_low", 32'(ifc.tx_ready), 32'd0);
        ifc.tx_data  = 8'h3C;
        ifc.tx_valid = 1'b1;
        @(negedge clk_in);
        ifc.tx_valid = 1'b0;
      end
    join
    wait_idle("ign");
    frame_checks("ign", frame, seen, 8'hA5, 1'b1);
    check("ign_phases", 32'(inh_phases - p0), 32'd1);
    check("ign_done", 32'(done_cnt - d0), 32'd1);

`ifdef PS2_TX_RETRY_EN
    // NACK on 0xFF then ack on the retry: two inhibit phases, one done, no error.
    snap();
    send_byte(8'hFF);
    device_frame(11, 1'b0, frame, seen);
    check("retry_busy_between", 32'(ifc.busy), 32'd1);
    device_frame(11, 1'b1, frame2, seen2);
    wait_idle("retry");
    frame_checks("retry_1st", frame, seen, 8'hFF, 1'b1);
    frame_checks("retry_2nd", frame2, seen2, 8'hFF, 1'b1);
    check("retry_phases", 32'(inh_phases - p0), 32'd2);
    check("retry_done", 32'(done_cnt - d0), 32'd1);
    check("retry_error", 32'(err_cnt - e0), 32'd0);
`else
    // NACK on 0x5A (four ones -> parity 1): single error, no done.
    snap();
    send_byte(8'h5A);
    device_frame(11, 1'b0, frame, seen);
    wait_idle("nack");
    frame_checks("nack", frame, seen, 8'h5A, 1'b1);
    check("nack_error", 32'(err_cnt - e0), 32'd1);
    check("nack_done", 32'(done_cnt - d0), 32'd0);
    check("nack_phases", 32'(inh_phases - p0), 32'd1);

    // Device silent: error exactly TO cycles after REQ entry, lines released.
    snap();
    send_byte(8'h12);
    t = 0;
    while (!(ps2_data_drive_low && !ps2_clock_drive_low) && t < 2000) begin
      @(negedge clk_in);
      t++;
    end
    check("to_req_seen", 32'(t < 2000), 32'd1);
    t = 0;
    while (!ifc.error && t < TO + 50) begin
      @(negedge clk_in);
      t++;
    end
    check("to_latency", 32'(t), 32'(TO));
    check("to_clk_drv", 32'(ps2_clock_drive_low), 32'd0);
    check("to_dat_drv", 32'(ps2_data_drive_low), 32'd0);
    check("to_busy", 32'(ifc.busy), 32'd0);
    check("to_done_low", 32'(ifc.done), 32'd0);
    $display("[TB] timeout: error after %0d cycles", t);
    repeat (3) @(negedge clk_in);
    #1;
    check("to_error_count", 32'(err_cnt - e0), 32'd1);
    check("to_done_count", 32'(done_cnt - d0), 32'd0);
`endif

    repeat (5) @(negedge clk_in);
    #1;
    check("done_error_exclusive", 32'(both_pulse_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
